// File: rtl/sbox_share_ctrl.sv
// sbox_share_ctrl: round-robin sharing of one merged AES S-box core among NREQ word requesters
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/data/inv  : per-requester word request (word i at req_data[32i+:32])
//   req_ready           : one-hot accept, only in IDLE
//   sb_in/sb_inv/sb_in_valid, sb_out : serial byte interface to the external S-box core
//   rsp_valid/ready/data/id/inv      : substituted word response
//   busy                : any state other than IDLE
module sbox_share_ctrl #(
    parameter int NREQ     = 4,
    parameter int SBOX_LAT = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [32*NREQ-1:0]       req_data,
    input  logic [NREQ-1:0]          req_inv,
    output logic [NREQ-1:0]          req_ready,
    output logic [7:0]               sb_in,
    output logic                     sb_inv,
    output logic                     sb_in_valid,
    input  logic [7:0]               sb_out,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_data,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic                     rsp_inv,
    output logic                     busy
);
    localparam int IW = $clog2(NREQ);
    localparam logic [NREQ-1:0] ONE = 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

    state_t state, state_n;
    logic [IW-1:0] ptr, gnt, id;
    logic [31:0] word, res;
    logic [1:0] cnt, cap_k;
    logic inv, found, acc, cap_v;

    always_comb begin
        found = 1'b0;
        gnt = ptr;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_valid[IW'((int'(ptr) + i) % NREQ)]) begin
                found = 1'b1;
                gnt = IW'((int'(ptr) + i) % NREQ);
            end
        end
    end

    assign req_ready   = (state == IDLE && found && !rst) ? ONE << gnt : '0;
    assign acc         = |(req_valid & req_ready);
    assign sb_in_valid = state == ISSUE;
    assign sb_in       = sb_in_valid ? word[8*cnt +: 8] : '0;
    assign sb_inv      = sb_in_valid & inv;
    assign rsp_valid   = state == RESP;
    assign rsp_data    = rsp_valid ? res : '0;
    assign rsp_id      = rsp_valid ? id : '0;
    assign rsp_inv     = rsp_valid & inv;
    assign busy        = state != IDLE;

    // The byte index travels alongside the valid bit so each returning
    // S-box byte lands in its own slot without looking at sb_out timing.
    if (SBOX_LAT == 0) begin : g_comb
        assign cap_v = sb_in_valid;
        assign cap_k = cnt;
    end else begin : g_pipe
        logic [SBOX_LAT-1:0] tv;
        logic [1:0] tk [SBOX_LAT];
        always_ff @(posedge clk) begin
            tk[0] <= cnt;
            for (int i = 1; i < SBOX_LAT; i++) tk[i] <= tk[i-1];
            if (rst) begin
                tv <= '0;
            end else begin
                tv[0] <= sb_in_valid;
                for (int i = 1; i < SBOX_LAT; i++) tv[i] <= tv[i-1];
            end
        end
        assign cap_v = tv[SBOX_LAT-1];
        assign cap_k = tk[SBOX_LAT-1];
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = acc ? ISSUE : IDLE;
            ISSUE:   state_n = cnt == 2'd3 ? (SBOX_LAT > 0 ? DRAIN : RESP) : ISSUE;
            DRAIN:   state_n = (cap_v && cap_k == 2'd3) ? RESP : DRAIN;
            RESP:    state_n = rsp_ready ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            word  <= '0;
            inv   <= 1'b0;
            id    <= '0;
            cnt   <= '0;
            res   <= '0;
        end else begin
            state <= state_n;
            cnt   <= state == ISSUE ? cnt + 2'd1 : 2'd0;
            if (acc) begin
                word <= req_data[32*gnt +: 32];
                inv  <= req_inv[gnt];
                id   <= gnt;
                ptr  <= IW'((int'(gnt) + 1) % NREQ);
            end
            if (cap_v) res[8*cap_k +: 8] <= sb_out;
        end
    end
endmodule
